// File: rtl/ins_cache_if.sv
// Fetch-side and memCtr-side signals of the instruction cache.
// The slave modport is the cache. The master modport is its environment (fetch stage plus memCtr).
interface ins_cache_if;
    logic        if_req;
    logic [31:0] if_pc;
    logic        if_valid;
    logic [31:0] if_ins;
    logic        mem_fetch_sig;
    logic [31:0] mem_fetch_addr;
    logic        mem_fetch_done;
    logic [63:0] mem_fetch_data;

    modport master (
        output if_req, if_pc, mem_fetch_done, mem_fetch_data,
        input  if_valid, if_ins, mem_fetch_sig, mem_fetch_addr
    );

    modport slave (
        input  if_req, if_pc, mem_fetch_done, mem_fetch_data,
        output if_valid, if_ins, mem_fetch_sig, mem_fetch_addr
    );
endinterface

// File: rtl/ins_cache.sv
// Direct-mapped, read-only instruction cache with 64-bit lines.
// A miss refills one line from memCtr over a sig/done handshake.
module ins_cache #(
    parameter int unsigned INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    ins_cache_if.slave  bus
);
    localparam int unsigned LINES = 1 << INDEX_BITS;
    localparam int unsigned TAG_W = 29 - INDEX_BITS;

    typedef enum logic {IDLE, MISS} state_e;

    state_e             state_q, state_d;
    logic               if_valid_q, if_valid_d;
    logic [31:0]        if_ins_q, if_ins_d;
    logic               sig_q, sig_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:2]        miss_pc_q, miss_pc_d;

    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [63:0]        data_q [LINES];

    logic                  fill_we_c;
    logic [INDEX_BITS-1:0] req_idx_c, fill_idx_c;
    logic [TAG_W-1:0]      req_tag_c;
    logic [63:0]           rd_line_c;
    logic                  hit_c;

    assign req_idx_c  = bus.if_pc[3 +: INDEX_BITS];
    assign req_tag_c  = bus.if_pc[31 -: TAG_W];
    assign fill_idx_c = miss_pc_q[3 +: INDEX_BITS];
    assign rd_line_c  = data_q[req_idx_c];
    assign hit_c      = valid_q[req_idx_c] && (tag_q[req_idx_c] == req_tag_c);

    // Next state. The cycle where if_valid is already high acks the held request.
    always_comb begin
        state_d    = state_q;
        if_valid_d = 1'b0;
        if_ins_d   = if_ins_q;
        sig_d      = sig_q;
        addr_d     = addr_q;
        miss_pc_d  = miss_pc_q;
        fill_we_c  = 1'b0;
        if (rdy) begin
            case (state_q)
                IDLE: begin
                    if (!clear && bus.if_req && !if_valid_q) begin
                        if (hit_c) begin
                            if_valid_d = 1'b1;
                            if_ins_d   = bus.if_pc[2] ? rd_line_c[63:32] : rd_line_c[31:0];
                        end else begin
                            sig_d     = 1'b1;
                            addr_d    = {bus.if_pc[31:3], 3'b000};
                            miss_pc_d = bus.if_pc[31:2];
                            state_d   = MISS;
                        end
                    end
                end
                MISS: begin
                    // A completed line is always kept, even when clear discards the result.
                    if (bus.mem_fetch_done) begin
                        fill_we_c = 1'b1;
                        sig_d     = 1'b0;
                        state_d   = IDLE;
                        if (!clear) begin
                            if_valid_d = 1'b1;
                            if_ins_d   = miss_pc_q[2] ? bus.mem_fetch_data[63:32]
                                                      : bus.mem_fetch_data[31:0];
                        end
                    end else if (clear) begin
                        sig_d   = 1'b0;
                        addr_d  = 32'(0);
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            if_valid_q <= 1'b0;
            if_ins_q   <= 32'(0);
            sig_q      <= 1'b0;
            addr_q     <= 32'(0);
            miss_pc_q  <= 30'(0);
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            if_valid_q <= if_valid_d;
            if_ins_q   <= if_ins_d;
            sig_q      <= sig_d;
            addr_q     <= addr_d;
            miss_pc_q  <= miss_pc_d;
            if (fill_we_c) valid_q[fill_idx_c] <= 1'b1;
        end
    end

    // Tag and data storage needs no reset; the valid bits gate every lookup.
    always_ff @(posedge clk) begin
        if (fill_we_c) begin
            tag_q[fill_idx_c]  <= miss_pc_q[31 -: TAG_W];
            data_q[fill_idx_c] <= bus.mem_fetch_data;
        end
    end

    assign bus.if_valid       = if_valid_q;
    assign bus.if_ins         = if_ins_q;
    assign bus.mem_fetch_sig  = sig_q;
    assign bus.mem_fetch_addr = addr_q;
endmodule

// File: tb/tb_ins_cache.sv
// Scoreboard bench for ins_cache. It covers reset, hits, misses, conflicts, clear and rdy freezes.
module tb_ins_cache;
    logic clk = 1'b0;
    logic rst, rdy, clear;
    always #5 clk = ~clk;

    ins_cache_if bus ();
    ins_cache #(.INDEX_BITS(4)) dut (.clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .bus(bus));

    int          errors = 0;
    int          checks = 0;
    int          valid_cnt = 0;
    logic [31:0] sb [$];
    bit          m_valid [16];
    logic [24:0] m_tag   [16];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] line_of(input logic [31:0] a);
        logic [31:0] b;
        b = {a[31:3], 3'b000};
        if (b == 32'h1000) return 64'h00000013_00100093;
        return {b ^ 32'hC0DE_0004, b ^ 32'h5A5A_0000};
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] pc);
        logic [63:0] l;
        l = line_of(pc);
        return pc[2] ? l[63:32] : l[31:0];
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        return m_valid[pc[6:3]] && (m_tag[pc[6:3]] == pc[31:7]);
    endfunction

    task automatic model_fill(input logic [31:0] pc);
        m_valid[pc[6:3]] = 1'b1;
        m_tag[pc[6:3]]   = pc[31:7];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every if_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.if_valid === 1'b1) begin
            valid_cnt++;
            if (sb.size() == 0) check("spurious_valid", 64'd1, 64'd0);
            else                check("if_ins", 64'(bus.if_ins), 64'(sb.pop_front()));
        end
    end

    // Full request: hit or two-cycle miss refill, then the ack cycle with the request still held.
    task automatic access(input logic [31:0] pc);
        bit miss;
        int c0;
        miss = !model_hit(pc);
        c0   = valid_cnt;
        bus.if_req = 1'b1;
        bus.if_pc  = pc;
        sb.push_back(exp_word(pc));
        tick();
        if (!miss) begin
            check("hit_valid", 64'(bus.if_valid), 64'd1);
            check("hit_sig", 64'(bus.mem_fetch_sig), 64'd0);
        end else begin
            check("miss_valid", 64'(bus.if_valid), 64'd0);
            check("miss_sig", 64'(bus.mem_fetch_sig), 64'd1);
            check("miss_addr", 64'(bus.mem_fetch_addr), 64'({pc[31:3], 3'b000}));
            tick();
            check("miss_hold_sig", 64'(bus.mem_fetch_sig), 64'd1);
            bus.mem_fetch_done = 1'b1;
            bus.mem_fetch_data = line_of(pc);
            tick();
            bus.mem_fetch_done = 1'b0;
            check("fill_valid", 64'(bus.if_valid), 64'd1);
            check("fill_sig", 64'(bus.mem_fetch_sig), 64'd0);
            model_fill(pc);
        end
        tick();
        check("ack_no_reserve", 64'(bus.if_valid), 64'd0);
        bus.if_req = 1'b0;
        tick();
        check("one_pulse", 64'(valid_cnt - c0), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        logic [31:0] pc;
        rst = 1'b1; rdy = 1'b1; clear = 1'b0;
        bus.if_req = 1'b0; bus.if_pc = 32'h0;
        bus.mem_fetch_done = 1'b0; bus.mem_fetch_data = 64'h0;
        repeat (2) tick();
        check("rst_valid", 64'(bus.if_valid), 64'd0);
        check("rst_ins", 64'(bus.if_ins), 64'd0);
        check("rst_sig", 64'(bus.mem_fetch_sig), 64'd0);
        check("rst_addr", 64'(bus.mem_fetch_addr), 64'd0);
        rst = 1'b0;
        tick();

        // Cold miss, then a hit on the other word of the same line.
        access(32'h1000);
        access(32'h1004);

        // Reset in the middle of a miss drops the outputs at once and forgets the cache contents.
        bus.if_req = 1'b1; bus.if_pc = 32'h1008;
        tick();
        check("pre_rst_sig", 64'(bus.mem_fetch_sig), 64'd1);
        #3 rst = 1'b1;
        #1;
        check("async_sig", 64'(bus.mem_fetch_sig), 64'd0);
        check("async_addr", 64'(bus.mem_fetch_addr), 64'd0);
        check("async_ins", 64'(bus.if_ins), 64'd0);
        check("async_valid", 64'(bus.if_valid), 64'd0);
        bus.if_req = 1'b0;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        access(32'h1000);

        // Conflict on index 0.
        access(32'h1080);
        access(32'h1000);
        access(32'h1004);

        // Clear two cycles into a miss aborts the fetch.
        c0 = valid_cnt;
        bus.if_req = 1'b1; bus.if_pc = 32'h2000;
        tick();
        check("abort_sig", 64'(bus.mem_fetch_sig), 64'd1);
        check("abort_addr", 64'(bus.mem_fetch_addr), 64'h2000);
        tick();
        tick();
        clear = 1'b1; bus.if_req = 1'b0;
        tick();
        clear = 1'b0;
        check("abort_sig_low", 64'(bus.mem_fetch_sig), 64'd0);
        check("abort_addr_zero", 64'(bus.mem_fetch_addr), 64'd0);
        tick();
        check("abort_no_valid", 64'(valid_cnt - c0), 64'd0);

        // Fresh miss. A clear that coincides with done still keeps the line.
        bus.if_req = 1'b1; bus.if_pc = 32'h2000;
        tick();
        check("fresh_sig", 64'(bus.mem_fetch_sig), 64'd1);
        tick();
        bus.mem_fetch_done = 1'b1; bus.mem_fetch_data = line_of(32'h2000);
        clear = 1'b1; bus.if_req = 1'b0;
        tick();
        bus.mem_fetch_done = 1'b0; clear = 1'b0;
        check("coinc_valid", 64'(bus.if_valid), 64'd0);
        check("coinc_sig", 64'(bus.mem_fetch_sig), 64'd0);
        model_fill(32'h2000);
        tick();
        check("coinc_no_pulse", 64'(valid_cnt - c0), 64'd0);
        access(32'h2000);

        // rdy low for three cycles during a miss.
        bus.if_req = 1'b1; bus.if_pc = 32'h4000;
        sb.push_back(exp_word(32'h4000));
        tick();
        check("frz_miss_sig", 64'(bus.mem_fetch_sig), 64'd1);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("frz_sig", 64'(bus.mem_fetch_sig), 64'd1);
            check("frz_addr", 64'(bus.mem_fetch_addr), 64'h4000);
            check("frz_valid", 64'(bus.if_valid), 64'd0);
        end
        rdy = 1'b1;
        bus.mem_fetch_done = 1'b1; bus.mem_fetch_data = line_of(32'h4000);
        tick();
        bus.mem_fetch_done = 1'b0;
        check("frz_fill_valid", 64'(bus.if_valid), 64'd1);
        model_fill(32'h4000);
        tick();
        bus.if_req = 1'b0;
        tick();

        // rdy low for three cycles during a hit.
        rdy = 1'b0;
        bus.if_req = 1'b1; bus.if_pc = 32'h4004;
        sb.push_back(exp_word(32'h4004));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("frz_hit_valid", 64'(bus.if_valid), 64'd0);
            check("frz_hit_sig", 64'(bus.mem_fetch_sig), 64'd0);
        end
        rdy = 1'b1;
        tick();
        check("frz_hit_resume", 64'(bus.if_valid), 64'd1);
        tick();
        bus.if_req = 1'b0;
        tick();

        // Mixed traffic over a few lines and two tags.
        for (int i = 0; i < 24; i++) begin
            pc = 32'h8000 + (32'($urandom_range(0, 1)) << 7) + (32'($urandom_range(0, 3)) << 3)
                 + (32'($urandom_range(0, 1)) << 2);
            access(pc);
        end

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
